// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator arbiter: function codes and default widths.
package cmp_pkg;

  localparam int DATA_W   = 32;
  localparam int TAG_W    = 4;
  localparam int CMP_NREQ = 2;

  typedef enum logic [2:0] {
    CMP_EQ      = 3'b000,
    CMP_NE      = 3'b001,
    CMP_GE_S    = 3'b010,
    CMP_LT_S    = 3'b011,
    CMP_GT_U    = 3'b100,
    CMP_LT_U    = 3'b101,
    CMP_GE_U    = 3'b110,
    CMP_SUB_OVF = 3'b111
  } cmp_fn_e;

endpackage

// File: rtl/cmp.sv
// Combinational single-bit comparator over two DATA_W operands.
// Zero latency; no flow control.
module cmp #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  input  logic [2:0]        fn_i,
  output logic              res_o
);
  import cmp_pkg::*;

  logic [DATA_W-1:0] diff;
  logic              eq;
  logic              lt_u;
  logic              lt_s;
  logic              ovf;
  cmp_fn_e           fn;

  assign fn   = cmp_fn_e'(fn_i);
  assign diff = x_i - y_i;
  assign eq   = (x_i == y_i);
  assign lt_u = (x_i < y_i);
  assign lt_s = ($signed(x_i) < $signed(y_i));
  // Subtraction overflows only when operand signs differ and the result sign flips from x.
  assign ovf  = (x_i[DATA_W-1] ^ y_i[DATA_W-1]) & (diff[DATA_W-1] ^ x_i[DATA_W-1]);

  always_comb begin
    res_o = 1'b0;
    unique case (fn)
      CMP_EQ:      res_o = eq;
      CMP_NE:      res_o = ~eq;
      CMP_GE_S:    res_o = ~lt_s;
      CMP_LT_S:    res_o = lt_s;
      CMP_GT_U:    res_o = ~lt_u & ~eq;
      CMP_LT_U:    res_o = lt_u;
      CMP_GE_U:    res_o = ~lt_u;
      CMP_SUB_OVF: res_o = ovf;
      default:     res_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin two-port arbiter sharing one comparator; registered result per port slot.
// A port is blocked only while its own slot is full and not being consumed.
module cmp_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_0,
  output logic              req_ready_0,
  input  logic [DATA_W-1:0] req_x_0,
  input  logic [DATA_W-1:0] req_y_0,
  input  logic [2:0]        req_fn_0,
  input  logic [TAG_W-1:0]  req_tag_0,
  output logic              rsp_valid_0,
  input  logic              rsp_ready_0,
  output logic [DATA_W-1:0] rsp_cmp_0,
  output logic [TAG_W-1:0]  rsp_tag_0,
  input  logic              req_valid_1,
  output logic              req_ready_1,
  input  logic [DATA_W-1:0] req_x_1,
  input  logic [DATA_W-1:0] req_y_1,
  input  logic [2:0]        req_fn_1,
  input  logic [TAG_W-1:0]  req_tag_1,
  output logic              rsp_valid_1,
  input  logic              rsp_ready_1,
  output logic [DATA_W-1:0] rsp_cmp_1,
  output logic [TAG_W-1:0]  rsp_tag_1,
  output logic [15:0]       stat_conflict
);
  import cmp_pkg::*;

  logic              elig_0, elig_1;
  logic              grant_0, grant_1;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] mux_x, mux_y;
  logic [2:0]        mux_fn;
  logic              cmp_res;
  logic [DATA_W-1:0] cmp_word;

  logic              valid_0_q, valid_0_d, valid_1_q, valid_1_d;
  logic [DATA_W-1:0] cmp_0_q, cmp_0_d, cmp_1_q, cmp_1_d;
  logic [TAG_W-1:0]  tag_0_q, tag_0_d, tag_1_q, tag_1_d;
  logic [15:0]       conflict_q, conflict_d;

  assign elig_0 = req_valid_0 && (!valid_0_q || rsp_ready_0);
  assign elig_1 = req_valid_1 && (!valid_1_q || rsp_ready_1);

  // On a tie the port that did not win last time is served.
  assign grant_0 = elig_0 && (!elig_1 || last_grant_q);
  assign grant_1 = elig_1 && !grant_0;

  assign req_ready_0 = grant_0;
  assign req_ready_1 = grant_1;

  assign mux_x  = grant_1 ? req_x_1  : req_x_0;
  assign mux_y  = grant_1 ? req_y_1  : req_y_0;
  assign mux_fn = grant_1 ? req_fn_1 : req_fn_0;

  cmp #(.DATA_W(DATA_W)) u_cmp (
    .x_i   (mux_x),
    .y_i   (mux_y),
    .fn_i  (mux_fn),
    .res_o (cmp_res)
  );

  assign cmp_word = {{(DATA_W-1){1'b0}}, cmp_res};

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_0) last_grant_d = 1'b0;
    if (grant_1) last_grant_d = 1'b1;

    valid_0_d = valid_0_q && !rsp_ready_0;
    cmp_0_d   = cmp_0_q;
    tag_0_d   = tag_0_q;
    if (grant_0) begin
      valid_0_d = 1'b1;
      cmp_0_d   = cmp_word;
      tag_0_d   = req_tag_0;
    end

    valid_1_d = valid_1_q && !rsp_ready_1;
    cmp_1_d   = cmp_1_q;
    tag_1_d   = tag_1_q;
    if (grant_1) begin
      valid_1_d = 1'b1;
      cmp_1_d   = cmp_word;
      tag_1_d   = req_tag_1;
    end

    conflict_d = conflict_q;
    if (elig_0 && elig_1 && (conflict_q != 16'hFFFF)) conflict_d = conflict_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      valid_0_q    <= 1'b0;
      cmp_0_q      <= '0;
      tag_0_q      <= '0;
      valid_1_q    <= 1'b0;
      cmp_1_q      <= '0;
      tag_1_q      <= '0;
      conflict_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      valid_0_q    <= valid_0_d;
      cmp_0_q      <= cmp_0_d;
      tag_0_q      <= tag_0_d;
      valid_1_q    <= valid_1_d;
      cmp_1_q      <= cmp_1_d;
      tag_1_q      <= tag_1_d;
      conflict_q   <= conflict_d;
    end
  end

  assign rsp_valid_0   = valid_0_q;
  assign rsp_cmp_0     = cmp_0_q;
  assign rsp_tag_0     = tag_0_q;
  assign rsp_valid_1   = valid_1_q;
  assign rsp_cmp_1     = cmp_1_q;
  assign rsp_tag_1     = tag_1_q;
  assign stat_conflict = conflict_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter with a per-port response scoreboard and arbitration model.
module tb_cmp_arbiter;
  localparam int DW = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid_0 = 0, req_valid_1 = 0;
  logic          req_ready_0, req_ready_1;
  logic [DW-1:0] req_x_0 = '0, req_y_0 = '0, req_x_1 = '0, req_y_1 = '0;
  logic [2:0]    req_fn_0 = '0, req_fn_1 = '0;
  logic [TW-1:0] req_tag_0 = '0, req_tag_1 = '0;
  logic          rsp_valid_0, rsp_valid_1;
  logic          rsp_ready_0 = 0, rsp_ready_1 = 0;
  logic [DW-1:0] rsp_cmp_0, rsp_cmp_1;
  logic [TW-1:0] rsp_tag_0, rsp_tag_1;
  logic [15:0]   stat_conflict;

  always #5 clk = ~clk;

  cmp_arbiter #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_x_0(req_x_0), .req_y_0(req_y_0),
    .req_fn_0(req_fn_0), .req_tag_0(req_tag_0), .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
    .rsp_cmp_0(rsp_cmp_0), .rsp_tag_0(rsp_tag_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_x_1(req_x_1), .req_y_1(req_y_1),
    .req_fn_1(req_fn_1), .req_tag_1(req_tag_1), .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
    .rsp_cmp_1(rsp_cmp_1), .rsp_tag_1(rsp_tag_1),
    .stat_conflict(stat_conflict)
  );

  typedef struct packed {
    logic [DW-1:0] cmp;
    logic [TW-1:0] tag;
  } rsp_t;

  rsp_t        q0[$];
  rsp_t        q1[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        m_sv0, m_sv1, m_last;
  logic [15:0] m_conf;

  // Reference: evaluate in 33-bit arithmetic so overflow shows as bit32 != bit31.
  function automatic logic ref_cmp(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [2:0] fn);
    logic signed [DW:0] sx, sy, d;
    logic        [DW:0] ux, uy;
    sx = {x[DW-1], x};
    sy = {y[DW-1], y};
    ux = {1'b0, x};
    uy = {1'b0, y};
    d  = sx - sy;
    case (fn)
      3'd0:    return ux == uy;
      3'd1:    return ux != uy;
      3'd2:    return sx >= sy;
      3'd3:    return sx < sy;
      3'd4:    return ux > uy;
      3'd5:    return ux < uy;
      3'd6:    return ux >= uy;
      default: return d[DW] != d[DW-1];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sv0 = 0; m_sv1 = 0; m_last = 1; m_conf = 0;
    q0.delete(); q1.delete();
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step(input string tag);
    logic e0, e1, g0, g1;
    rsp_t r;
    #1;
    e0 = req_valid_0 && (!m_sv0 || rsp_ready_0);
    e1 = req_valid_1 && (!m_sv1 || rsp_ready_1);
    g0 = e0 && (!e1 || m_last);
    g1 = e1 && !g0;
    chk({tag, ".rdy0"}, DW'(req_ready_0), DW'(g0));
    chk({tag, ".rdy1"}, DW'(req_ready_1), DW'(g1));
    chk({tag, ".vld0"}, DW'(rsp_valid_0), DW'(m_sv0));
    chk({tag, ".vld1"}, DW'(rsp_valid_1), DW'(m_sv1));
    chk({tag, ".conf"}, DW'(stat_conflict), DW'(m_conf));
    if (rsp_valid_0) begin
      chk({tag, ".q0cnt"}, DW'(q0.size()), DW'(1));
      if (q0.size() > 0) begin
        r = q0[0];
        chk({tag, ".cmp0"}, rsp_cmp_0, r.cmp);
        chk({tag, ".tag0"}, DW'(rsp_tag_0), DW'(r.tag));
        if (rsp_ready_0) void'(q0.pop_front());
      end
    end
    if (rsp_valid_1) begin
      chk({tag, ".q1cnt"}, DW'(q1.size()), DW'(1));
      if (q1.size() > 0) begin
        r = q1[0];
        chk({tag, ".cmp1"}, rsp_cmp_1, r.cmp);
        chk({tag, ".tag1"}, DW'(rsp_tag_1), DW'(r.tag));
        if (rsp_ready_1) void'(q1.pop_front());
      end
    end
    if (req_valid_0 && req_ready_0) q0.push_back({DW'(ref_cmp(req_x_0, req_y_0, req_fn_0)), req_tag_0});
    if (req_valid_1 && req_ready_1) q1.push_back({DW'(ref_cmp(req_x_1, req_y_1, req_fn_1)), req_tag_1});
    if (e0 && e1 && m_conf != 16'hFFFF) m_conf = m_conf + 16'd1;
    if (g0) m_last = 1'b0;
    if (g1) m_last = 1'b1;
    m_sv0 = g0 | (m_sv0 & ~rsp_ready_0);
    m_sv1 = g1 | (m_sv1 & ~rsp_ready_1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive0(input logic v, input logic [DW-1:0] x, input logic [DW-1:0] y,
                        input logic [2:0] fn, input logic [TW-1:0] tag);
    req_valid_0 = v; req_x_0 = x; req_y_0 = y; req_fn_0 = fn; req_tag_0 = tag;
  endtask

  task automatic drive1(input logic v, input logic [DW-1:0] x, input logic [DW-1:0] y,
                        input logic [2:0] fn, input logic [TW-1:0] tag);
    req_valid_1 = v; req_x_1 = x; req_y_1 = y; req_fn_1 = fn; req_tag_1 = tag;
  endtask

  initial begin
    logic [DW-1:0] sx [2];
    logic [DW-1:0] sy [2];
    model_reset();
    #1;
    chk("rst.vld0", DW'(rsp_valid_0), 0);
    chk("rst.vld1", DW'(rsp_valid_1), 0);
    chk("rst.cmp0", rsp_cmp_0, 0);
    chk("rst.cmp1", rsp_cmp_1, 0);
    chk("rst.tag0", DW'(rsp_tag_0), 0);
    chk("rst.tag1", DW'(rsp_tag_1), 0);
    chk("rst.conf", DW'(stat_conflict), 0);
    chk("rst.rdy0", DW'(req_ready_0), 0);
    chk("rst.rdy1", DW'(req_ready_1), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Continuous contention: grants must alternate starting with port 0.
    rsp_ready_0 = 1; rsp_ready_1 = 1;
    for (int i = 0; i < 6; i++) begin
      drive0(1, 32'd1, 32'd2, 3'b011, TW'(i));
      drive1(1, 32'hFFFFFFFF, 32'd1, 3'b101, TW'(i + 8));
      #1;
      chk("alt.rdy0", DW'(req_ready_0), DW'((i % 2) == 0));
      step("alt");
    end
    chk("alt.conf", DW'(stat_conflict), 6);
    drive0(0, 0, 0, 0, 0); drive1(0, 0, 0, 0, 0);
    step("alt.drain");

    // Single port, equality, tag 3.
    drive0(1, 32'd5, 32'd5, 3'b000, 4'd3);
    step("eq");
    drive0(0, 0, 0, 0, 0);
    #1;
    chk("eq.cmp0", rsp_cmp_0, 1);
    chk("eq.tag0", DW'(rsp_tag_0), 3);
    step("eq.rsp");

    // Port 1 slot held full: port 0 must take every grant.
    rsp_ready_1 = 0;
    drive1(1, 32'd9, 32'd4, 3'b100, 4'd7);
    step("blk.fill");
    for (int i = 0; i < 4; i++) begin
      drive0(1, 32'(i), 32'd2, 3'b101, TW'(i + 1));
      drive1(1, 32'd0, 32'd1, 3'b000, 4'd12);
      step("blk");
    end
    chk("blk.tag1", DW'(rsp_tag_1), 7);
    drive0(0, 0, 0, 0, 0);
    rsp_ready_1 = 1;
    step("blk.rel");
    drive1(0, 0, 0, 0, 0);
    step("blk.drain");
    step("blk.idle");

    // Slot rewritten in the same cycle it is consumed.
    drive0(1, 32'd1, 32'd1, 3'b001, 4'd5);
    step("rep.a");
    drive0(1, 32'd2, 32'd1, 3'b001, 4'd6);
    step("rep.b");
    drive0(0, 0, 0, 0, 0);
    #1;
    chk("rep.vld0", DW'(rsp_valid_0), 1);
    chk("rep.tag0", DW'(rsp_tag_0), 6);
    step("rep.c");

    // Function sweep, port 0 streaming back-to-back.
    sx[0] = 32'h80000000; sy[0] = 32'd1;
    sx[1] = 32'd3;        sy[1] = 32'd7;
    for (int p = 0; p < 2; p++) begin
      for (int f = 0; f < 8; f++) begin
        drive0(1, sx[p], sy[p], 3'(f), TW'(f + 8 * p));
        step("sweep");
      end
    end
    drive0(1, 32'h80000000, 32'd1, 3'b111, 4'd15);
    step("ovf");
    drive0(0, 0, 0, 0, 0);
    #1;
    chk("ovf.cmp0", rsp_cmp_0, 1);
    step("ovf.rsp");

    // Fill both slots, then assert reset asynchronously mid-cycle.
    rsp_ready_0 = 0; rsp_ready_1 = 0;
    drive0(1, 32'd1, 32'd1, 3'b000, 4'd1);
    drive1(1, 32'd2, 32'd1, 3'b100, 4'd2);
    step("arst.f1");
    step("arst.f2");
    drive0(0, 0, 0, 0, 0); drive1(0, 0, 0, 0, 0);
    #2;
    rst_n = 0;
    #1;
    chk("arst.vld0", DW'(rsp_valid_0), 0);
    chk("arst.vld1", DW'(rsp_valid_1), 0);
    chk("arst.conf", DW'(stat_conflict), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    rsp_ready_0 = 1; rsp_ready_1 = 1;
    drive0(1, 32'd4, 32'd4, 3'b110, 4'd9);
    drive1(1, 32'd4, 32'd5, 3'b011, 4'd10);
    #1;
    chk("arst.tie0", DW'(req_ready_0), 1);
    step("arst.t0");
    step("arst.t1");
    drive0(0, 0, 0, 0, 0); drive1(0, 0, 0, 0, 0);
    step("end.d0");
    step("end.d1");
    chk("end.q0", DW'(q0.size()), 0);
    chk("end.q1", DW'(q1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
